// File: rtl/trig_frame_gen_if.sv
// Signal bundle for trig_frame_gen: pixel enable, line timing inputs,
// frame trigger and the three video timing outputs.
interface trig_frame_gen_if #(
    parameter int DW = 12
);
    logic          ena;
    logic [DW-1:0] Thsync;
    logic [DW-1:0] Thlen;
    logic          trig;
    logic          hsync;
    logic          vsync;
    logic          daten;

    // Driver side (pixel-enable source / trigger source)
    modport master (
        output ena, Thsync, Thlen, trig,
        input  hsync, vsync, daten
    );

    // Timing generator side
    modport slave (
        input  ena, Thsync, Thlen, trig,
        output hsync, vsync, daten
    );
endinterface

// File: rtl/trig_frame_gen.sv
// Triggered single-frame video timing generator.
// A trigger pulse arms the block; on the next pixel-enable tick it latches
// the line timing and plays out exactly one frame of hsync/vsync/daten,
// then returns to idle.
// Optional build macro TRIG_FRAME_GEN_CLKGEN_EN: derive the pixel enable
// from an internal divide-by-CLK_DIV counter instead of the ena input.
module trig_frame_gen #(
    parameter int DW          = 12,
    parameter int VLINES      = 20,
    parameter int VSYNC_LINES = 2,
    parameter int VBP_LINES   = 2,
    parameter int HBP         = 8,
    parameter int HFP         = 8,
    parameter int CLK_DIV     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    trig_frame_gen_if.slave  bus
);

    localparam int            VW     = (VLINES > 1) ? $clog2(VLINES) : 1;
    localparam logic [VW-1:0] V_LAST = VW'(VLINES - 1);
    localparam logic [VW:0]   V_VS   = (VW+1)'(VSYNC_LINES);
    localparam logic [VW:0]   V_DE   = (VW+1)'(VSYNC_LINES + VBP_LINES);
    localparam logic [DW:0]   HBP_W  = (DW+1)'(HBP);
    localparam logic [DW:0]   HFP_W  = (DW+1)'(HFP);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // ------------------------------------------------------------------
    // Pixel tick source
    // ------------------------------------------------------------------
    logic tick;

`ifdef TRIG_FRAME_GEN_CLKGEN_EN
    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          unused_ena;

    assign tick       = (div_cnt == DIV_LAST);
    assign unused_ena = bus.ena;

    // Free-running divider; tick on the last count, CLK_DIV=1 ticks every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + CW'(1);
    end
`else
    logic [31:0] unused_clk_div;

    assign tick           = bus.ena;
    assign unused_clk_div = CLK_DIV;
`endif

    // ------------------------------------------------------------------
    // Output decode from a counter position; sums kept at DW+1 bits so
    // Thsync+HBP and h+HFP cannot wrap.
    // ------------------------------------------------------------------
    function automatic logic [2:0] frame_outs(
        input logic [DW-1:0] hh,
        input logic [VW-1:0] vv,
        input logic [DW-1:0] ths,
        input logic [DW-1:0] thl
    );
        logic [DW:0] he;
        logic        hs, vs, de;
        he = {1'b0, hh};
        hs = (he < {1'b0, ths});
        vs = ({1'b0, vv} < V_VS);
        de = ({1'b0, vv} >= V_DE) &&
             (he >= ({1'b0, ths} + HBP_W)) &&
             ((he + HFP_W) < {1'b0, thl});
        return {hs, vs, de};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic          pending, pending_n;
    logic [DW-1:0] h, h_n;
    logic [VW-1:0] v, v_n;
    logic [DW-1:0] ths_l, ths_n;
    logic [DW-1:0] thl_l, thl_n;
    logic [2:0]    outs_r, outs_n;   // {hsync, vsync, daten}

    // State, counters, latched timing and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            h       <= '0;
            v       <= '0;
            ths_l   <= '0;
            thl_l   <= '0;
            outs_r  <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            h       <= h_n;
            v       <= v_n;
            ths_l   <= ths_n;
            thl_l   <= thl_n;
            outs_r  <= outs_n;
        end
    end

    // Trigger arming, frame start, counter advance and output decode
    always_comb begin
        state_n   = state;
        pending_n = pending;
        h_n       = h;
        v_n       = v;
        ths_n     = ths_l;
        thl_n     = thl_l;
        outs_n    = outs_r;

        if (state == IDLE) begin
            if (pending && tick) begin
                // Start edge: latch timing; a line shorter than 2 pixels
                // is rejected and the request is simply consumed.
                pending_n = 1'b0;
                ths_n     = bus.Thsync;
                thl_n     = bus.Thlen;
                if (bus.Thlen >= DW'(2)) begin
                    state_n = ACTIVE;
                    h_n     = '0;
                    v_n     = '0;
                    outs_n  = frame_outs('0, '0, bus.Thsync, bus.Thlen);
                end
            end else if (!pending && bus.trig) begin
                pending_n = 1'b1;
            end
        end else if (tick) begin
            // Triggers while active are dropped: pending is only set in IDLE
            if (h == thl_l - DW'(1)) begin
                h_n = '0;
                if (v == V_LAST) begin
                    state_n = IDLE;
                    v_n     = '0;
                end else begin
                    v_n = v + VW'(1);
                end
            end else begin
                h_n = h + DW'(1);
            end
            if (state_n == ACTIVE) outs_n = frame_outs(h_n, v_n, ths_l, thl_l);
            else                   outs_n = '0;
        end
    end

    assign bus.hsync = outs_r[2];
    assign bus.vsync = outs_r[1];
    assign bus.daten = outs_r[0];

endmodule

// File: tb/tb_trig_frame_gen.sv
// Self-checking bench for trig_frame_gen. A tick-index frame model
// (h = t mod Thlen, v = t div Thlen) predicts outputs every clock;
// per-frame pulse totals are also checked against closed-form counts.
module tb_trig_frame_gen;

    localparam int DW          = 12;
    localparam int VLINES      = 20;
    localparam int VSYNC_LINES = 2;
    localparam int VBP_LINES   = 2;
    localparam int HBP         = 8;
    localparam int HFP         = 8;
    localparam int CLK_DIV     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    trig_frame_gen_if #(.DW(DW)) bus ();

    trig_frame_gen #(
        .DW(DW), .VLINES(VLINES), .VSYNC_LINES(VSYNC_LINES),
        .VBP_LINES(VBP_LINES), .HBP(HBP), .HFP(HFP), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state
    bit m_busy, m_pend;
    int m_t, m_ths, m_thl, m_div;
    int ena_cnt  = 0;
    bit ena_rand = 0;
    int cnt_h, cnt_v, cnt_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] m_out();
        int hh, vv;
        logic hs, vs, de;
        if (!m_busy) return 3'b000;
        hh = m_t % m_thl;
        vv = m_t / m_thl;
        hs = (hh < m_ths);
        vs = (vv < VSYNC_LINES);
        de = (vv >= VSYNC_LINES + VBP_LINES) && (hh >= m_ths + HBP) && (hh < m_thl - HFP);
        return {hs, vs, de};
    endfunction

    function automatic void m_clear();
        m_busy = 0; m_pend = 0; m_t = 0; m_div = 0;
    endfunction

    // One clock: drive inputs at a negedge, advance the model across the
    // coming posedge, then check outputs at the following negedge.
    task automatic step(input bit trg);
        bit e;
`ifdef TRIG_FRAME_GEN_CLKGEN_EN
        bus.ena = 1'b0;
        e = (m_div == CLK_DIV - 1);
        m_div = (m_div + 1) % CLK_DIV;
`else
        e = ena_rand ? ($urandom_range(0, 2) == 0) : (ena_cnt % 2 == 1);
        ena_cnt++;
        bus.ena = e;
`endif
        bus.trig = trg;
        if (!m_busy) begin
            if (m_pend && e) begin
                m_pend = 0;
                if (int'(bus.Thlen) >= 2) begin
                    m_busy = 1; m_t = 0;
                    m_ths = int'(bus.Thsync); m_thl = int'(bus.Thlen);
                end
            end else if (!m_pend && trg) begin
                m_pend = 1;
            end
        end else if (e) begin
            m_t++;
            if (m_t == VLINES * m_thl) begin
                m_busy = 0; m_t = 0;
            end
        end
        @(negedge clk);
        chk("outs", {29'd0, bus.hsync, bus.vsync, bus.daten}, {29'd0, m_out()});
        cnt_h += int'(bus.hsync);
        cnt_v += int'(bus.vsync);
        cnt_d += int'(bus.daten);
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        bus.trig = 1'b0;
        #1;
        chk("rst_imm", {29'd0, bus.hsync, bus.vsync, bus.daten}, 32'd0);
        m_clear();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Trigger one frame with alternating pixel enable and check totals.
    task automatic run_frame(input int ths, input int thl, input int mid_trig,
                             input int chg_at, input int chg_val);
        int n, dw, eh, ev, ed;
        bus.Thsync = DW'(ths);
        bus.Thlen  = DW'(thl);
        cnt_h = 0; cnt_v = 0; cnt_d = 0;
        step(1'b1);
        n = (thl >= 2) ? VLINES * thl * 2 + 40 : 40;
        for (int i = 1; i <= n; i++) begin
            if (i == chg_at) bus.Thsync = DW'(chg_val);
            step(i == mid_trig);
        end
        if (thl >= 2) begin
            dw = (thl - HFP) - (ths + HBP);
            if (dw < 0) dw = 0;
            eh = VLINES * ((ths < thl) ? ths : thl) * 2;
            ev = VSYNC_LINES * thl * 2;
            ed = (VLINES - VSYNC_LINES - VBP_LINES) * dw * 2;
        end else begin
            eh = 0; ev = 0; ed = 0;
        end
        chk("hsync_clks", cnt_h, eh);
        chk("vsync_clks", cnt_v, ev);
        chk("daten_clks", cnt_d, ed);
    endtask

    initial begin
        bus.ena    = 1'b0;
        bus.trig   = 1'b0;
        bus.Thsync = DW'(16);
        bus.Thlen  = DW'(200);
        m_clear();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", {29'd0, bus.hsync, bus.vsync, bus.daten}, 32'd0);
        end
        rst_n = 1'b1;

        // Idle after reset: nothing happens without a trigger
        cnt_h = 0; cnt_v = 0; cnt_d = 0;
        repeat (1000) step(1'b0);
        chk("idle_act", cnt_h + cnt_v + cnt_d, 0);

        // Two identical frames
        run_frame(16, 200, -1, -1, 0);
        run_frame(16, 200, -1, -1, 0);
        // Trigger mid-frame is dropped
        run_frame(16, 200, 3000, -1, 0);
        // Thsync change mid-frame only affects the next frame
        run_frame(16, 200, -1, 3000, 40);
        run_frame(40, 200, -1, -1, 0);
        // Too-short line: no frame
        run_frame(16, 1, -1, -1, 0);

        // Reset mid-frame, then a full frame
        bus.Thsync = DW'(16);
        bus.Thlen  = DW'(200);
        step(1'b1);
        repeat (2000) step(1'b0);
        do_reset(3);
        run_frame(16, 200, -1, -1, 0);

        // Randomized timing, enables and triggers
        ena_rand = 1;
        for (int it = 0; it < 10; it++) begin
            bus.Thsync = DW'($urandom_range(0, 20));
            bus.Thlen  = DW'($urandom_range(0, 40));
            for (int c = 0; c < 1200; c++) begin
                if ($urandom_range(0, 299) == 0) bus.Thsync = DW'($urandom_range(0, 20));
                step($urandom_range(0, 49) == 0);
            end
            if (it == 5) do_reset($urandom_range(1, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
